axi_lite_regbank: RTL and testbench
===================================

# axi_lite_regbank

Parametrised AXI4-Lite register bank, the successor to the fixed four-register slave. Its register count and data width are configurable, and selected registers can be marked read-only so they return live status inputs. Write address and write data are accepted independently through one-entry holding buffers, and response backpressure is honoured. It sits between the AXI-Lite interconnect and peripheral control/status logic, exposing all writable registers as a flat output bus.

## Interface
- ADDR_WIDTH, 32: AW_ADDR/AR_ADDR width.
- DATA_WIDTH, 32: bus and register width; 32 or 64 only.
- NUM_REGS, 8: register count; power of two, 2..64.
- RO_MASK, 0: NUM_REGS-bit mask; bit i set makes register i read-only.
- RESET_VAL, 0: DATA_WIDTH-bit reset value of every writable register.
- A_CLK  in  1  clock; all logic on rising edge.
- A_RESET_n  in  1  asynchronous active-low reset.
- AW_ADDR  in  ADDR_WIDTH; AW_VALID  in  1; AW_READY  out  1  write address channel.
- W_DATA  in  DATA_WIDTH; W_STRB  in  DATA_WIDTH/8; W_VALID  in  1; W_READY  out  1  write data channel.
- B_RESP  out  2; B_VALID  out  1; B_READY  in  1  write response channel.
- AR_ADDR  in  ADDR_WIDTH; AR_VALID  in  1; AR_READY  out  1  read address channel.
- R_DATA  out  DATA_WIDTH; R_RESP  out  2; R_VALID  out  1; R_READY  in  1  read data channel.
- RO_IN  in  NUM_REGS*DATA_WIDTH  live status; slice i is read when register i is read-only.
- REG_OUT  out  NUM_REGS*DATA_WIDTH  stored register values; read-only slots drive 0.

## Operation
- Address decode:
  - Let B = log2(DATA_WIDTH/8) and K = log2(NUM_REGS).
  - Register index is addr[B+K-1:B]. Bits below B are ignored.
  - Any set bit in addr[ADDR_WIDTH-1:B+K] is out of range.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Write path:
  - AW buffer and W buffer each hold one beat and fill independently, in either order or in the same cycle.
  - Commit fires on the first edge where both buffers are full and the B channel is free (B_VALID=0, or B_VALID&B_READY on that edge).
  - Commit in range and writable: update bytes whose W_STRB bit is set. An all-zero strobe is OKAY with no change. B_RESP=OKAY.
  - Commit out of range, or to a read-only index: no update, B_RESP=SLVERR.
  - Commit sets B_VALID and empties both buffers. B_VALID clears on the B handshake edge unless a new commit occurs on that same edge.
- Read path:
  - On the AR handshake edge, R_DATA, R_RESP and R_VALID are loaded.
  - Writable register: stored value, OKAY.
  - Read-only register: RO_IN slice sampled on that edge, OKAY.
  - Out of range: R_DATA=0, R_RESP=SLVERR.
  - R_DATA/R_RESP stay stable while R_VALID=1 and R_READY=0.
- Read and write paths are independent. A read handshake on the same edge as a commit to the same register returns the pre-write value.
- REG_OUT updates on the commit edge.

## Timing
- Reset, asynchronous, any time:
  - All outputs go to 0; writable registers go to RESET_VAL.
  - Both buffers empty; in-flight transactions are discarded with no response.
- AW_READY / W_READY:
  - Registered; equal to "buffer empty".
  - Go 1 on the first edge after reset release.
  - Fall on their own handshake edge; rise again on the commit edge.
- Write latency: AW and W handshakes on edge N, commit and B_VALID=1 after edge N+1.
- Write throughput: with B_READY held high, the next AW/W handshake can occur at N+2, giving one write per 2 cycles.
- Write backpressure: if B_VALID is held by B_READY=0, the commit of the next buffered write waits. AW_READY and W_READY stay 0 until that commit.
- AR_READY:
  - Registered; rises on the first edge after reset release.
  - Falls on the AR handshake edge; rises on the R handshake edge.
- Read latency: AR handshake on edge N, R_VALID=1 after N.
- Read throughput: one read per 2 cycles with R_READY high.
- A VALID output never drops before its handshake; payload never changes while VALID=1 without a handshake.

## Test plan
- Defaults: write 0x12345678 to 0x04 with strobe 0xF, then read 0x04 -> B_RESP=00, R_DATA=0x12345678, R_RESP=00, REG_OUT slice 1 = 0x12345678.
- W 0xAABBCCDD, strobe 0x5, presented 3 cycles before AW 0x08 -> W_READY drops, AW accepted later; register 2 = 0x00BB00DD; B_VALID one cycle after the AW handshake.
- RO_MASK=0x01, RO_IN slice 0 = 0xCAFEF00D: write 0x00 -> SLVERR, no change; read 0x00 -> 0xCAFEF00D, OKAY.
- Write 0x40 and read 0x40 (NUM_REGS=8) -> both SLVERR, R_DATA=0; reading 0x05 returns register 1 with OKAY.
- B_READY=0 for 4 cycles with a second AW/W queued -> first B_VALID/B_RESP held stable; second commit on the B handshake edge; B_VALID stays 1 for the second response.
- Assert A_RESET_n=0 mid-write with the AW buffer full -> all outputs 0 immediately, registers = RESET_VAL; after release the first write completes normally.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: parameterised register count/width, read-only status slots,
// one-entry AW/W holding buffers and B/R backpressure.

module axi_lite_regbank_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   q_o
);
    logic [DATA_WIDTH-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (we_i && strb_i[b]) val_d[8*b +: 8] = data_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) val_q <= RESET_VAL;
        else         val_q <= val_d;
    end

    assign q_o = val_q;
endmodule

module axi_lite_regbank #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           A_CLK,
    input  logic                           A_RESET_n,
    input  logic [ADDR_WIDTH-1:0]          AW_ADDR,
    input  logic                           AW_VALID,
    output logic                           AW_READY,
    input  logic [DATA_WIDTH-1:0]          W_DATA,
    input  logic [DATA_WIDTH/8-1:0]        W_STRB,
    input  logic                           W_VALID,
    output logic                           W_READY,
    output logic [1:0]                     B_RESP,
    output logic                           B_VALID,
    input  logic                           B_READY,
    input  logic [ADDR_WIDTH-1:0]          AR_ADDR,
    input  logic                           AR_VALID,
    output logic                           AR_READY,
    output logic [DATA_WIDTH-1:0]          R_DATA,
    output logic [1:0]                     R_RESP,
    output logic                           R_VALID,
    input  logic                           R_READY,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] RO_IN,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT
);
    localparam int STRB_W = DATA_WIDTH/8;
    localparam int B      = $clog2(STRB_W);
    localparam int K      = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (B + K)) != '0;
    endfunction

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] ro_slots;
    assign ro_slots = RO_IN;
    assign REG_OUT  = regs;

    // Byte-offset bits never take part in decode.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AW_ADDR[B-1:0], AR_ADDR[B-1:0]};

    // ---------------- write path ----------------
    logic              aw_full_q, aw_full_d, aw_ready_q;
    logic [K-1:0]      aw_idx_q;
    logic              aw_err_q;
    logic              w_full_q, w_full_d, w_ready_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              b_valid_q;
    logic [1:0]        b_resp_q;
    logic              aw_hs, w_hs, commit;

    always_comb begin
        aw_hs     = AW_VALID & aw_ready_q;
        w_hs      = W_VALID & w_ready_q;
        commit    = aw_full_q & w_full_q & (~b_valid_q | B_READY);
        aw_full_d = commit ? 1'b0 : (aw_full_q | aw_hs);
        w_full_d  = commit ? 1'b0 : (w_full_q | w_hs);
    end

    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            aw_full_q  <= 1'b0;
            aw_ready_q <= 1'b0;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            w_full_q   <= 1'b0;
            w_ready_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_ready_q <= ~aw_full_d;
            w_full_q   <= w_full_d;
            w_ready_q  <= ~w_full_d;
            // Decode at accept time so the commit edge only needs a compare.
            if (aw_hs) begin
                aw_idx_q <= AW_ADDR[B+K-1:B];
                aw_err_q <= addr_oor(AW_ADDR) | RO_MASK[AW_ADDR[B+K-1:B]];
            end
            if (w_hs) begin
                w_data_q <= W_DATA;
                w_strb_q <= W_STRB;
            end
            if (commit) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
            end else if (B_READY) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    assign AW_READY = aw_ready_q;
    assign W_READY  = w_ready_q;
    assign B_VALID  = b_valid_q;
    assign B_RESP   = b_resp_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign regs[i] = '0;
        end else begin : g_rw
            axi_lite_regbank_reg #(
                .DATA_WIDTH (DATA_WIDTH),
                .RESET_VAL  (RESET_VAL)
            ) u_reg (
                .clk_i  (A_CLK),
                .rst_ni (A_RESET_n),
                .we_i   (commit && !aw_err_q && (aw_idx_q == K'(i))),
                .strb_i (w_strb_q),
                .data_i (w_data_q),
                .q_o    (regs[i])
            );
        end
    end

    // ---------------- read path ----------------
    logic                  ar_ready_q, ar_hs;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [K-1:0]          rd_idx;

    always_comb begin
        ar_hs     = AR_VALID & ar_ready_q;
        rd_idx    = AR_ADDR[B+K-1:B];
        r_valid_d = ar_hs | (r_valid_q & ~R_READY);
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (ar_hs) begin
            if (addr_oor(AR_ADDR)) begin
                r_data_d = '0;
                r_resp_d = RESP_SLVERR;
            end else if (RO_MASK[rd_idx]) begin
                r_data_d = ro_slots[rd_idx];
                r_resp_d = RESP_OKAY;
            end else begin
                r_data_d = regs[rd_idx];
                r_resp_d = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            // One read outstanding: address side reopens once R is consumed.
            ar_ready_q <= ~r_valid_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign AR_READY = ar_ready_q;
    assign R_VALID  = r_valid_q;
    assign R_DATA   = r_data_q;
    assign R_RESP   = r_resp_q;
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank with a queue-based reference model and per-cycle compare.

module tb_axi_lite_regbank;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam logic [NR-1:0] ROM = 8'h01;

    logic A_CLK, A_RESET_n;
    logic [AW-1:0] AW_ADDR, AR_ADDR;
    logic AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic AR_VALID, AR_READY, R_VALID, R_READY;
    logic [DW-1:0] W_DATA, R_DATA;
    logic [DW/8-1:0] W_STRB;
    logic [1:0] B_RESP, R_RESP;
    logic [NR-1:0][DW-1:0] ro_in, reg_out;

    axi_lite_regbank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(ROM), .RESET_VAL(32'h0)
    ) dut (
        .A_CLK(A_CLK), .A_RESET_n(A_RESET_n),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
        .RO_IN(ro_in), .REG_OUT(reg_out)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input string what);
        n_vec++;
        n_miss++;
        $display("FAIL %s: %s", nm, what);
    endtask

    // ---------------- reference model ----------------
    logic [NR-1:0][DW-1:0] mdl = '0;
    logic [31:0] awq[$];
    logic [35:0] wq[$];
    logic [33:0] rq[$];
    logic ar_hs_seen = 1'b0, b_hs_last = 1'b0, r_hs_last = 1'b0;
    logic prev_bv = 1'b0, prev_rv = 1'b0;
    logic [1:0]  held_b = 2'b00;
    logic [33:0] held_r = '0;

    function automatic logic [1:0] exp_wresp(input logic [31:0] a);
        int idx;
        idx = int'(a / 4) % NR;
        if (a >= NR*4 || ROM[idx]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] a);
        int idx;
        idx = int'(a / 4) % NR;
        if (a >= NR*4) return {2'b10, 32'h0};
        if (ROM[idx])  return {2'b00, ro_in[idx]};
        return {2'b00, mdl[idx]};
    endfunction

    always @(posedge A_CLK) begin
        ar_hs_seen = 1'b0;
        b_hs_last  = 1'b0;
        r_hs_last  = 1'b0;
        if (A_RESET_n) begin
            if (AW_VALID && AW_READY) awq.push_back(AW_ADDR);
            if (W_VALID && W_READY)   wq.push_back({W_STRB, W_DATA});
            if (AR_VALID && AR_READY) begin
                rq.push_back(exp_read(AR_ADDR));
                ar_hs_seen = 1'b1;
            end
            b_hs_last = B_VALID && B_READY;
            r_hs_last = R_VALID && R_READY;
        end
    end

    always @(negedge A_CLK) begin
        logic [31:0] a;
        logic [35:0] w;
        logic [33:0] e;
        logic [1:0]  er;
        int idx;
        if (!A_RESET_n) begin
            chk("reset_outputs", {AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_RESP, R_DATA}, '0);
            chk("reset_regout", reg_out, '0);
            awq.delete(); wq.delete(); rq.delete();
            mdl = '0;
            prev_bv = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (B_VALID && (!prev_bv || b_hs_last)) begin
                if (awq.size() == 0 || wq.size() == 0) begin
                    flag("b_spurious", "B_VALID rose with no accepted AW/W pair, want no response");
                end else begin
                    a  = awq.pop_front();
                    w  = wq.pop_front();
                    er = exp_wresp(a);
                    if (er == 2'b00) begin
                        idx = int'(a / 4) % NR;
                        for (int b = 0; b < 4; b++)
                            if (w[32+b]) mdl[idx][8*b +: 8] = w[8*b +: 8];
                    end
                    chk("b_resp", B_RESP, er);
                    held_b = er;
                end
            end else if (B_VALID) begin
                chk("b_hold", B_RESP, held_b);
            end
            chk("reg_out", reg_out, mdl);
            if (ar_hs_seen) chk("r_latency", R_VALID, 1'b1);
            if (R_VALID && (!prev_rv || r_hs_last)) begin
                if (rq.size() == 0) begin
                    flag("r_spurious", "R_VALID rose with no accepted AR, want no response");
                end else begin
                    e = rq.pop_front();
                    chk("r_data", R_DATA, e[31:0]);
                    chk("r_resp", R_RESP, e[33:32]);
                    held_r = e;
                end
            end else if (R_VALID) begin
                chk("r_hold", {R_RESP, R_DATA}, held_r);
            end
            prev_bv = B_VALID;
            prev_rv = R_VALID;
        end
    end

    // ---------------- drivers (start and end on a falling edge) ----------------
    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        AW_ADDR = a; AW_VALID = 1'b1;
        while (!AW_READY && n < 50) begin @(negedge A_CLK); n++; end
        if (!AW_READY) flag("aw_handshake", "AW_READY stayed 0, want 1 within 50 cycles");
        @(negedge A_CLK);
        AW_VALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        W_DATA = d; W_STRB = s; W_VALID = 1'b1;
        while (!W_READY && n < 50) begin @(negedge A_CLK); n++; end
        if (!W_READY) flag("w_handshake", "W_READY stayed 0, want 1 within 50 cycles");
        @(negedge A_CLK);
        W_VALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        AR_ADDR = a; AR_VALID = 1'b1;
        while (!AR_READY && n < 50) begin @(negedge A_CLK); n++; end
        if (!AR_READY) flag("ar_handshake", "AR_READY stayed 0, want 1 within 50 cycles");
        @(negedge A_CLK);
        AR_VALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] r);
        int n = 0;
        while (!B_VALID && n < 50) begin @(negedge A_CLK); n++; end
        if (!B_VALID) flag("b_timeout", "B_VALID stayed 0, want 1 within 50 cycles");
        r = B_RESP;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        while (!R_VALID && n < 50) begin @(negedge A_CLK); n++; end
        if (!R_VALID) flag("r_timeout", "R_VALID stayed 0, want 1 within 50 cycles");
        d = R_DATA;
        r = R_RESP;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b(r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        send_ar(a);
        wait_r(d, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] d;
        A_RESET_n = 1'b0;
        AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
        AW_ADDR = '0; AR_ADDR = '0; W_DATA = '0; W_STRB = '0;
        B_READY = 1'b1; R_READY = 1'b1;
        for (int i = 0; i < NR; i++) ro_in[i] = 32'hC0DE0000 + i;
        ro_in[0] = 32'hCAFEF00D;
        repeat (3) @(negedge A_CLK);
        A_RESET_n = 1'b1;
        @(negedge A_CLK);
        chk("ready_after_reset", {AW_READY, W_READY, AR_READY}, 3'b111);

        // basic write / read
        wr(32'h04, 32'h12345678, 4'hF, br);
        chk("t1_bresp", br, 2'b00);
        rd(32'h04, d, rr);
        chk("t1_rdata", d, 32'h12345678);
        chk("t1_rresp", rr, 2'b00);
        chk("t1_regout1", reg_out[1], 32'h12345678);

        // W ahead of AW, partial strobe
        fork
            send_w(32'hAABBCCDD, 4'h5);
            begin
                @(negedge A_CLK);
                chk("t2_wready_drop", W_READY, 1'b0);
                repeat (2) @(negedge A_CLK);
                send_aw(32'h08);
            end
        join
        chk("t2_b_not_yet", B_VALID, 1'b0);
        @(negedge A_CLK);
        chk("t2_b_latency", B_VALID, 1'b1);
        wait_b(br);
        chk("t2_bresp", br, 2'b00);
        rd(32'h08, d, rr);
        chk("t2_rdata", d, 32'h00BB00DD);
        chk("t2_regout2", reg_out[2], 32'h00BB00DD);

        // read-only slot
        wr(32'h00, 32'h11111111, 4'hF, br);
        chk("t3_bresp", br, 2'b10);
        rd(32'h00, d, rr);
        chk("t3_rdata", d, 32'hCAFEF00D);
        chk("t3_rresp", rr, 2'b00);
        chk("t3_regout0", reg_out[0], 32'h0);

        // out of range and ignored low address bits
        wr(32'h40, 32'hFFFFFFFF, 4'hF, br);
        chk("t4_bresp", br, 2'b10);
        rd(32'h40, d, rr);
        chk("t4_rdata", d, 32'h0);
        chk("t4_rresp", rr, 2'b10);
        rd(32'h05, d, rr);
        chk("t4_rdata_lsb", d, 32'h12345678);
        chk("t4_rresp_lsb", rr, 2'b00);

        // all-zero strobe
        wr(32'h04, 32'hDEADBEEF, 4'h0, br);
        chk("t4b_bresp", br, 2'b00);
        rd(32'h04, d, rr);
        chk("t4b_rdata", d, 32'h12345678);

        // read on the commit edge of the same register sees the old value
        fork
            send_aw(32'h0C);
            send_w(32'hFFFFFFFF, 4'hF);
            begin @(negedge A_CLK); send_ar(32'h0C); end
        join
        wait_r(d, rr);
        chk("t4c_pre_write", d, 32'h0);
        wait_b(br);
        chk("t4c_bresp", br, 2'b00);
        rd(32'h0C, d, rr);
        chk("t4c_post_write", d, 32'hFFFFFFFF);

        // B backpressure with a second write queued
        B_READY = 1'b0;
        wr(32'h10, 32'h01010101, 4'hF, br);
        chk("t5_bresp1", br, 2'b00);
        fork
            send_aw(32'h14);
            send_w(32'h02020202, 4'hF);
        join
        repeat (2) begin
            chk("t5_b_held", B_VALID, 1'b1);
            chk("t5_aw_stall", AW_READY, 1'b0);
            chk("t5_reg5_wait", reg_out[5], 32'h0);
            @(negedge A_CLK);
        end
        B_READY = 1'b1;
        @(negedge A_CLK);
        chk("t5_b_second", B_VALID, 1'b1);
        chk("t5_reg5", reg_out[5], 32'h02020202);
        chk("t5_reg4", reg_out[4], 32'h01010101);
        @(negedge A_CLK);
        chk("t5_b_done", B_VALID, 1'b0);

        // asynchronous reset with the AW buffer full
        send_aw(32'h18);
        chk("t6_aw_full", AW_READY, 1'b0);
        #2 A_RESET_n = 1'b0;
        #1;
        chk("t6_reset_async", {AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_RESP, R_DATA}, '0);
        chk("t6_regs_reset", reg_out, '0);
        repeat (2) @(negedge A_CLK);
        A_RESET_n = 1'b1;
        @(negedge A_CLK);
        chk("t6_ready", {AW_READY, W_READY, AR_READY}, 3'b111);
        wr(32'h18, 32'h5A5A5A5A, 4'hF, br);
        chk("t6_bresp", br, 2'b00);
        rd(32'h18, d, rr);
        chk("t6_rdata", d, 32'h5A5A5A5A);
        chk("t6_reg1_cleared", reg_out[1], 32'h0);

        repeat (3) @(negedge A_CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
